// File: rtl/wb_regfile_pkg.sv
// Shared core constants used by the pipeline stages and the register file.
package wb_regfile_pkg;
    localparam int XLEN = 32;
    localparam int NREGS = 32;
    localparam int REG_AW = $clog2(NREGS);
    localparam logic [REG_AW-1:0] ZERO_REG = '0;
endpackage

// File: rtl/wb_bypass.sv
// Per-port write-through select, built only with REGFILE_BYPASS_EN.
module wb_bypass #(
    parameter int XLEN = 32,
    parameter int AW = 5
) (
    input  logic [AW-1:0]   addr,
    input  logic            we,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic [XLEN-1:0] rf_data,
    output logic [XLEN-1:0] rd_data
);
    // we already excludes x0, so a hit can never be on index 0
    assign rd_data = (we && addr == wb_rd) ? wb_data : rf_data;
endmodule

// File: rtl/wb_regfile.sv
// Writeback-stage register file; REGFILE_BYPASS_EN adds write-through reads.
module wb_regfile #(
    parameter int XLEN = wb_regfile_pkg::XLEN,
    parameter int NREGS = wb_regfile_pkg::NREGS,
    localparam int AW = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wb_valid,
    input  logic            wb_regwrite,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            wb_ack,
    output logic [15:0]     wr_count
);
    import wb_regfile_pkg::*;

    logic [XLEN-1:0] regs [1:NREGS-1];
    logic            we;
    logic [XLEN-1:0] rf1;
    logic [XLEN-1:0] rf2;

    assign we = wb_valid & wb_regwrite & (wb_rd != AW'(ZERO_REG));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NREGS; i++)
                regs[i] <= '0;
            wb_ack   <= 1'b0;
            wr_count <= '0;
        end else begin
            wb_ack <= we;
            if (we) begin
                regs[wb_rd] <= wb_data;
                wr_count    <= wr_count + 16'd1;
            end
        end
    end

    // x0 is not storage; it is decoded to zero here
    assign rf1 = (rs1_addr == AW'(ZERO_REG)) ? '0 : regs[rs1_addr];
    assign rf2 = (rs2_addr == AW'(ZERO_REG)) ? '0 : regs[rs2_addr];

`ifdef REGFILE_BYPASS_EN
    wb_bypass #(.XLEN(XLEN), .AW(AW)) u_byp1 (
        .addr    (rs1_addr),
        .we      (we),
        .wb_rd   (wb_rd),
        .wb_data (wb_data),
        .rf_data (rf1),
        .rd_data (rs1_data)
    );
    wb_bypass #(.XLEN(XLEN), .AW(AW)) u_byp2 (
        .addr    (rs2_addr),
        .we      (we),
        .wb_rd   (wb_rd),
        .wb_data (wb_data),
        .rf_data (rf2),
        .rd_data (rs2_data)
    );
`else
    assign rs1_data = rf1;
    assign rs2_data = rf2;
`endif
endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: vector table plus reset, same-cycle and wrap sequences.
module tb_wb_regfile;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_valid, wb_regwrite;
    logic [4:0]  wb_rd, rs1_addr, rs2_addr;
    logic [31:0] wb_data, rs1_data, rs2_data;
    logic        wb_ack;
    logic [15:0] wr_count;

    int passed = 0;
    int total = 0;

    typedef struct {
        logic        v;
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] d;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] e1;
        logic [31:0] e2;
        logic        eack;
        logic [15:0] ecnt;
    } vec_t;

    vec_t tbl [8];

    wb_regfile dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wb_valid    (wb_valid),
        .wb_regwrite (wb_regwrite),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .wb_ack      (wb_ack),
        .wr_count    (wr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic [4:0] rd,
                         input logic [31:0] d);
        wb_valid = v;
        wb_regwrite = rw;
        wb_rd = rd;
        wb_data = d;
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b1, 5'd1,  32'h0000_1234, 5'd1,  5'd0,
                   32'h0000_1234, 32'h0, 1'b1, 16'd1};
        tbl[1] = '{1'b1, 1'b1, 5'd0,  32'hFFFF_FFFF, 5'd1,  5'd0,
                   32'h0000_1234, 32'h0, 1'b0, 16'd1};
        tbl[2] = '{1'b0, 1'b1, 5'd7,  32'hA5A5_A5A5, 5'd7,  5'd1,
                   32'h0, 32'h0000_1234, 1'b0, 16'd1};
        tbl[3] = '{1'b1, 1'b0, 5'd7,  32'h0000_5555, 5'd7,  5'd7,
                   32'h0, 32'h0, 1'b0, 16'd1};
        tbl[4] = '{1'b1, 1'b1, 5'd3,  32'h0000_0011, 5'd3,  5'd3,
                   32'h11, 32'h11, 1'b1, 16'd2};
        tbl[5] = '{1'b1, 1'b1, 5'd31, 32'hCAFE_F00D, 5'd31, 5'd3,
                   32'hCAFE_F00D, 32'h11, 1'b1, 16'd3};
        tbl[6] = '{1'b1, 1'b1, 5'd5,  32'hDEAD_BEEF, 5'd5,  5'd31,
                   32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b1, 16'd4};
        tbl[7] = '{1'b0, 1'b0, 5'd0,  32'h0, 5'd5,  5'd1,
                   32'hDEAD_BEEF, 32'h0000_1234, 1'b0, 16'd4};

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 32'h0);
        rs1_addr = 5'd5;
        rs2_addr = 5'd0;
        #2;
        chk("reset_rs1", rs1_data, 32'h0);
        chk("reset_ack", {31'b0, wb_ack}, 32'h0);
        chk("reset_cnt", {16'b0, wr_count}, 32'h0);
        step();
        step();
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].v, tbl[i].rw, tbl[i].rd, tbl[i].d);
            rs1_addr = tbl[i].a1;
            rs2_addr = tbl[i].a2;
            step();
            chk($sformatf("vec%0d_rs1", i), rs1_data, tbl[i].e1);
            chk($sformatf("vec%0d_rs2", i), rs2_data, tbl[i].e2);
            chk($sformatf("vec%0d_ack", i), {31'b0, wb_ack}, {31'b0, tbl[i].eack});
            chk($sformatf("vec%0d_cnt", i), {16'b0, wr_count}, {16'b0, tbl[i].ecnt});
        end

        // same-cycle write and read of x3
        drive(1'b1, 1'b1, 5'd3, 32'h22);
        rs1_addr = 5'd3;
        rs2_addr = 5'd3;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("same_cycle_rs1", rs1_data, 32'h22);
`else
        chk("same_cycle_rs1", rs1_data, 32'h11);
`endif
        chk("same_cycle_eq", rs2_data, rs1_data);
        step();
        chk("after_edge_rs1", rs1_data, 32'h22);
        chk("after_edge_ack", {31'b0, wb_ack}, 32'h1);
        chk("after_edge_cnt", {16'b0, wr_count}, 32'h5);

        // asynchronous reset mid-run, no clock edge in between
        drive(1'b0, 1'b0, 5'd0, 32'h0);
        rs1_addr = 5'd5;
        rst_n = 1'b0;
        #1;
        chk("async_rst_x5", rs1_data, 32'h0);
        chk("async_rst_ack", {31'b0, wb_ack}, 32'h0);
        chk("async_rst_cnt", {16'b0, wr_count}, 32'h0);

        // write during reset is lost
        drive(1'b1, 1'b1, 5'd9, 32'h99);
        rs1_addr = 5'd9;
        step();
        drive(1'b0, 1'b0, 5'd0, 32'h0);
        rst_n = 1'b1;
        #1;
        chk("rst_write_lost", rs1_data, 32'h0);
        chk("rst_write_cnt", {16'b0, wr_count}, 32'h0);

        // first write after reset release
        drive(1'b1, 1'b1, 5'd9, 32'h99);
        step();
        chk("first_write_x9", rs1_data, 32'h99);
        chk("first_write_ack", {31'b0, wb_ack}, 32'h1);
        chk("first_write_cnt", {16'b0, wr_count}, 32'h1);

        // count wrap: 65534 more writes reach FFFF, one more wraps
        drive(1'b1, 1'b1, 5'd2, 32'h2);
        for (int i = 0; i < 65534; i++) @(posedge clk);
        #1;
        chk("cnt_ffff", {16'b0, wr_count}, 32'h0000_FFFF);
        step();
        chk("cnt_wrap", {16'b0, wr_count}, 32'h0);
        chk("wrap_ack", {31'b0, wb_ack}, 32'h1);
        drive(1'b0, 1'b0, 5'd0, 32'h0);
        step();
        chk("idle_ack", {31'b0, wb_ack}, 32'h0);
        chk("idle_cnt", {16'b0, wr_count}, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
